// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// default widths and the bit layout of a queued instruction entry.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PID_W   = 20;
    localparam int DEF_TID_W   = 16;
    localparam int DEF_CNT_W   = 64;
    localparam int DEF_QDEPTH  = 4;

    // Entry layout, LSB first: tid | pid | is64Bit | address | instruction
    function automatic int entry_off_pid(input int tidW);
        return tidW;
    endfunction

    function automatic int entry_off_mode(input int pidW, input int tidW);
        return tidW + pidW;
    endfunction

    function automatic int entry_off_addr(input int pidW, input int tidW);
        return tidW + pidW + 1;
    endfunction

    function automatic int entry_off_instr(input int addrW, input int pidW, input int tidW);
        return tidW + pidW + 1 + addrW;
    endfunction

    function automatic int entry_width(input int instrW, input int addrW, input int pidW, input int tidW);
        return instrW + addrW + pidW + tidW + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched instruction entries; flush empties it
// in one cycle and the head entry is presented combinationally.
module fetch_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full_o   = (r_count == CNT_W'(DEPTH));
    assign empty_o  = (r_count == '0);
    assign count_o  = r_count;
    assign data_o   = r_mem[r_rdPtr];
    assign w_doPop  = pop_i && !empty_o;
    assign w_doPush = push_i && (!full_o || w_doPop);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock_i) begin
        if (w_doPush && !flush_i) r_mem[r_wrPtr] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks the PC, issues one outstanding memory read at a
// time, queues returned words with their tags and hands them to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int addressWidth            = DEF_ADDR_W,
    parameter int instructionWidth        = DEF_INSTR_W,
    parameter int PidSize                 = DEF_PID_W,
    parameter int TidSize                 = DEF_TID_W,
    parameter int instructionCounterWidth = DEF_CNT_W,
    parameter int queueDepth              = DEF_QDEPTH,
    parameter logic [addressWidth-1:0] resetVector = '0
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic                               redirect_i,
    input  logic [addressWidth-1:0]            redirectAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    output logic                               memReq_o,
    output logic [addressWidth-1:0]            memAddress_o,
    input  logic                               memAck_i,
    input  logic [instructionWidth-1:0]        memData_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o
);

    localparam int ENTRY_W   = entry_width(instructionWidth, addressWidth, PidSize, TidSize);
    localparam int OFF_PID   = entry_off_pid(TidSize);
    localparam int OFF_MODE  = entry_off_mode(PidSize, TidSize);
    localparam int OFF_ADDR  = entry_off_addr(PidSize, TidSize);
    localparam int OFF_INSTR = entry_off_instr(addressWidth, PidSize, TidSize);
    localparam int QCNT_W    = $clog2(queueDepth) + 1;

    localparam logic [addressWidth-1:0] ALIGN_MASK    = ~addressWidth'(2'b11);
    localparam logic [addressWidth-1:0] LOW_WORD_MASK = addressWidth'({32{1'b1}});

    fetch_state_t                     r_state;
    fetch_state_t                     w_nextState;
    logic [addressWidth-1:0]          r_pc;
    logic [addressWidth-1:0]          r_memAddr;
    logic [instructionCounterWidth-1:0] r_majId;
    logic                             r_enable;
    logic [instructionWidth-1:0]      r_instr;
    logic [addressWidth-1:0]          r_instrAddr;
    logic                             r_mode;
    logic [PidSize-1:0]               r_pid;
    logic [TidSize-1:0]               r_tid;
    logic [instructionCounterWidth-1:0] r_majIdOut;

    logic                             w_issue;
    logic                             w_push;
    logic                             w_pop;
    logic [addressWidth-1:0]          w_pcInc;
    logic [addressWidth-1:0]          w_pcNext;
    logic [ENTRY_W-1:0]               w_pushData;
    logic [ENTRY_W-1:0]               w_head;
    logic                             w_full;
    logic                             w_empty;
    logic [QCNT_W-1:0]                w_count;

    assign w_pcInc    = r_pc + addressWidth'(4);
    // In 32-bit mode the upper word stays zero and the low word wraps.
    assign w_pcNext   = is64Bit_i ? w_pcInc : (w_pcInc & LOW_WORD_MASK);
    assign w_pushData = {memData_i, r_memAddr, is64Bit_i, pid_i, tid_i};
    assign w_pop      = !w_empty && enable_i && !stall_i && !redirect_i;

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && !redirect_i && (int'(w_count) < queueDepth)) begin
                    w_issue     = 1'b1;
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (memAck_i) begin
                    w_push      = !redirect_i && (!w_full || w_pop);
                    w_nextState = ST_IDLE;
                end else if (redirect_i) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (memAck_i) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state   <= ST_IDLE;
            r_pc      <= resetVector;
            r_memAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (redirect_i)  r_pc <= redirectAddress_i & ALIGN_MASK;
            else if (w_push) r_pc <= w_pcNext;
            if (w_issue)     r_memAddr <= r_pc;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (queueDepth)
    ) u_queue (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .data_i  (w_pushData),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Decode-facing registers: loaded on pop, held otherwise.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_enable    <= 1'b0;
            r_instr     <= '0;
            r_instrAddr <= '0;
            r_mode      <= 1'b0;
            r_pid       <= '0;
            r_tid       <= '0;
            r_majIdOut  <= '0;
            r_majId     <= '0;
        end else begin
            r_enable <= w_pop;
            if (w_pop) begin
                r_instr     <= w_head[OFF_INSTR +: instructionWidth];
                r_instrAddr <= w_head[OFF_ADDR +: addressWidth];
                r_mode      <= w_head[OFF_MODE];
                r_pid       <= w_head[OFF_PID +: PidSize];
                r_tid       <= w_head[0 +: TidSize];
                r_majIdOut  <= r_majId;
                r_majId     <= r_majId + 1'b1;
            end
        end
    end

    assign memReq_o             = (r_state != ST_IDLE);
    assign memAddress_o         = r_memAddr;
    assign enable_o             = r_enable;
    assign instruction_o        = r_instr;
    assign instructionAddress_o = r_instrAddr;
    assign is64Bit_o            = r_mode;
    assign instructionPid_o     = r_pid;
    assign instructionTid_o     = r_tid;
    assign instructionMajId_o   = r_majIdOut;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a responding memory model plus request and
// decode-side monitors, with one task per scenario.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirectAddress_i = '0;
    logic        is64Bit_i = 1'b1;
    logic [19:0] pid_i = 20'hABCDE;
    logic [15:0] tid_i = 16'h1234;
    logic        memReq_o;
    logic [63:0] memAddress_o;
    logic        memAck_i = 1'b0;
    logic [31:0] memData_i = '0;
    logic        enable_o;
    logic [31:0] instruction_o;
    logic [63:0] instructionAddress_o;
    logic        is64Bit_o;
    logic [19:0] instructionPid_o;
    logic [15:0] instructionTid_o;
    logic [63:0] instructionMajId_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic [63:0] majId;
        logic        mode;
        logic [19:0] pid;
        logic [15:0] tid;
        int          cyc;
    } out_t;

    logic [63:0] reqLog[$];
    out_t        outLog[$];
    int          cyc = 0;
    logic        prevReq = 1'b0;
    int          ackDelay = 1;
    int          waited = 0;

    always #5 clock_i = ~clock_i;

    fetch_unit dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .stall_i              (stall_i),
        .redirect_i           (redirect_i),
        .redirectAddress_i    (redirectAddress_i),
        .is64Bit_i            (is64Bit_i),
        .pid_i                (pid_i),
        .tid_i                (tid_i),
        .memReq_o             (memReq_o),
        .memAddress_o         (memAddress_o),
        .memAck_i             (memAck_i),
        .memData_i            (memData_i),
        .enable_o             (enable_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .is64Bit_o            (is64Bit_o),
        .instructionPid_o     (instructionPid_o),
        .instructionTid_o     (instructionTid_o),
        .instructionMajId_o   (instructionMajId_o)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    // Memory: after ackDelay request cycles, acknowledge for one cycle.
    always @(posedge clock_i) begin
        #1;
        if (memReq_o && !memAck_i) begin
            if (waited >= ackDelay) begin
                memAck_i  = 1'b1;
                memData_i = mem_word(memAddress_o);
                waited    = 0;
            end else begin
                waited++;
            end
        end else begin
            memAck_i = 1'b0;
            waited   = 0;
        end
    end

    always @(negedge clock_i) begin
        cyc++;
        if (memReq_o && !prevReq) reqLog.push_back(memAddress_o);
        prevReq = memReq_o;
        if (enable_o)
            outLog.push_back('{instructionAddress_o, instruction_o, instructionMajId_o,
                               is64Bit_o, instructionPid_o, instructionTid_o, cyc});
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        enable_i = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirectAddress_i = '0;
        is64Bit_i = 1'b1;
        ackDelay = 1;
        wait_neg(3);
        reqLog.delete();
        outLog.delete();
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        wait_neg(3);
        checks++; if (memReq_o !== 1'b0) begin failures++; $display("FAIL reset_memReq got=%0b exp=0", memReq_o); end
        checks++; if (enable_o !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0b exp=0", enable_o); end
        checks++; if (memAddress_o !== 64'h0) begin failures++; $display("FAIL reset_memAddr got=%h exp=0", memAddress_o); end
        checks++; if (instruction_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction_o); end
        checks++; if (instructionMajId_o !== 64'h0) begin failures++; $display("FAIL reset_majId got=%0d exp=0", instructionMajId_o); end
    endtask

    task automatic test_sequential();
        do_reset();
        enable_i = 1'b1;
        wait_neg(30);
        enable_i = 1'b0;
        checks++;
        if (reqLog.size() < 3 || outLog.size() < 3) begin
            failures++;
            $display("FAIL seq_count got req=%0d out=%0d exp>=3", reqLog.size(), outLog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [63:0] ea;
                ea = 64'(i * 4);
                checks++; if (reqLog[i] !== ea) begin failures++; $display("FAIL seq_req%0d got=%h exp=%h", i, reqLog[i], ea); end
                checks++; if (outLog[i].addr !== ea) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, outLog[i].addr, ea); end
                checks++; if (outLog[i].majId !== 64'(i)) begin failures++; $display("FAIL seq_majId%0d got=%0d exp=%0d", i, outLog[i].majId, i); end
                checks++; if (outLog[i].instr !== mem_word(ea)) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, outLog[i].instr, mem_word(ea)); end
            end
            checks++; if (outLog[0].pid !== 20'hABCDE) begin failures++; $display("FAIL seq_pid got=%h exp=abcde", outLog[0].pid); end
            checks++; if (outLog[0].tid !== 16'h1234) begin failures++; $display("FAIL seq_tid got=%h exp=1234", outLog[0].tid); end
            checks++; if (outLog[0].mode !== 1'b1) begin failures++; $display("FAIL seq_mode got=%0b exp=1", outLog[0].mode); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall_i = 1'b1;
        enable_i = 1'b1;
        wait_neg(20);
        checks++; if (reqLog.size() != 4) begin failures++; $display("FAIL stall_reqs got=%0d exp=4", reqLog.size()); end
        checks++; if (memReq_o !== 1'b0) begin failures++; $display("FAIL stall_memReq got=%0b exp=0", memReq_o); end
        checks++; if (outLog.size() != 0) begin failures++; $display("FAIL stall_out got=%0d exp=0", outLog.size()); end
        stall_i = 1'b0;
        wait_neg(6);
        checks++;
        if (outLog.size() < 4) begin
            failures++;
            $display("FAIL stall_release_count got=%0d exp>=4", outLog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (outLog[i].addr !== 64'(i * 4)) begin failures++; $display("FAIL stall_addr%0d got=%h exp=%h", i, outLog[i].addr, 64'(i * 4)); end
            end
            checks++;
            if (outLog[3].cyc - outLog[0].cyc != 3) begin failures++; $display("FAIL stall_consec got=%0d exp=3", outLog[3].cyc - outLog[0].cyc); end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_redirect();
        int i;
        do_reset();
        stall_i = 1'b1;
        enable_i = 1'b1;
        for (i = 0; i < 100 && reqLog.size() < 3; i++) wait_neg(1);
        checks++;
        if (reqLog.size() < 3) begin
            failures++;
            $display("FAIL redir_timeout got=%0d exp=3", reqLog.size());
        end else begin
            ackDelay = 3;
            redirectAddress_i = 64'h1002;
            redirect_i = 1'b1;
            wait_neg(1);
            redirect_i = 1'b0;
            checks++; if (memReq_o !== 1'b1) begin failures++; $display("FAIL redir_drain_req got=%0b exp=1", memReq_o); end
            wait_neg(20);
            ackDelay = 1;
            checks++;
            if (reqLog.size() < 4) begin failures++; $display("FAIL redir_newreq got=%0d exp>=4", reqLog.size()); end
            else if (reqLog[3] !== 64'h1000) begin failures++; $display("FAIL redir_newreq got=%h exp=1000", reqLog[3]); end
            stall_i = 1'b0;
            wait_neg(10);
            checks++;
            if (outLog.size() < 1) begin
                failures++;
                $display("FAIL redir_out got=%0d exp>=1", outLog.size());
            end else begin
                checks++; if (outLog[0].addr !== 64'h1000) begin failures++; $display("FAIL redir_first got=%h exp=1000", outLog[0].addr); end
                checks++; if (outLog[0].instr !== mem_word(64'h1000)) begin failures++; $display("FAIL redir_instr got=%h exp=%h", outLog[0].instr, mem_word(64'h1000)); end
                checks++; if (outLog[0].majId !== 64'h0) begin failures++; $display("FAIL redir_majId got=%0d exp=0", outLog[0].majId); end
                foreach (outLog[k]) begin
                    checks++;
                    if (outLog[k].addr < 64'h1000) begin failures++; $display("FAIL redir_stale got=%h exp>=1000", outLog[k].addr); end
                end
            end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_wrap(input logic mode, input logic [63:0] expNext);
        do_reset();
        stall_i = 1'b1;
        is64Bit_i = mode;
        redirectAddress_i = 64'hFFFF_FFFC;
        redirect_i = 1'b1;
        wait_neg(1);
        redirect_i = 1'b0;
        enable_i = 1'b1;
        wait_neg(8);
        checks++;
        if (reqLog.size() < 2) begin
            failures++;
            $display("FAIL wrap%0b_reqs got=%0d exp>=2", mode, reqLog.size());
        end else begin
            checks++; if (reqLog[0] !== 64'hFFFF_FFFC) begin failures++; $display("FAIL wrap%0b_first got=%h exp=fffffffc", mode, reqLog[0]); end
            checks++; if (reqLog[1] !== expNext) begin failures++; $display("FAIL wrap%0b_next got=%h exp=%h", mode, reqLog[1], expNext); end
        end
        stall_i = 1'b0;
        wait_neg(3);
        checks++;
        if (outLog.size() < 1) begin failures++; $display("FAIL wrap%0b_out got=%0d exp>=1", mode, outLog.size()); end
        else if (outLog[0].mode !== mode) begin failures++; $display("FAIL wrap%0b_modetag got=%0b exp=%0b", mode, outLog[0].mode, mode); end
        enable_i = 1'b0;
    endtask

    task automatic test_push_pop();
        bit found;
        found = 1'b0;
        do_reset();
        stall_i = 1'b1;
        enable_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_neg(1);
            if (memAck_i && dut.u_queue.count_o == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL pp_timeout got=0 exp=1");
        end else begin
            stall_i = 1'b0;
            wait_neg(1);
            stall_i = 1'b1;
            checks++; if (dut.u_queue.count_o !== 3'd3) begin failures++; $display("FAIL pp_count got=%0d exp=3", dut.u_queue.count_o); end
            checks++; if (enable_o !== 1'b1) begin failures++; $display("FAIL pp_enable got=%0b exp=1", enable_o); end
            checks++; if (instructionAddress_o !== 64'h0) begin failures++; $display("FAIL pp_addr got=%h exp=0", instructionAddress_o); end
            stall_i = 1'b0;
            wait_neg(10);
            checks++;
            if (outLog.size() < 5) begin
                failures++;
                $display("FAIL pp_outs got=%0d exp>=5", outLog.size());
            end else begin
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (outLog[i].addr !== 64'(i * 4)) begin failures++; $display("FAIL pp_order%0d got=%h exp=%h", i, outLog[i].addr, 64'(i * 4)); end
                end
            end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit found;
        found = 1'b0;
        do_reset();
        enable_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_neg(1);
            if (outLog.size() >= 2 && memReq_o) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rmw_timeout got=0 exp=1");
        end else begin
            reset_i = 1'b0;
            #1;
            checks++; if (memReq_o !== 1'b0) begin failures++; $display("FAIL rmw_memReq got=%0b exp=0", memReq_o); end
            checks++; if (enable_o !== 1'b0) begin failures++; $display("FAIL rmw_enable got=%0b exp=0", enable_o); end
            checks++; if (instructionMajId_o !== 64'h0) begin failures++; $display("FAIL rmw_majIdOut got=%0d exp=0", instructionMajId_o); end
            wait_neg(2);
            reqLog.delete();
            outLog.delete();
            reset_i = 1'b1;
            wait_neg(12);
            checks++;
            if (reqLog.size() < 1 || outLog.size() < 1) begin
                failures++;
                $display("FAIL rmw_restart got req=%0d out=%0d exp>=1", reqLog.size(), outLog.size());
            end else begin
                checks++; if (reqLog[0] !== 64'h0) begin failures++; $display("FAIL rmw_req got=%h exp=0", reqLog[0]); end
                checks++; if (outLog[0].addr !== 64'h0) begin failures++; $display("FAIL rmw_addr got=%h exp=0", outLog[0].addr); end
                checks++; if (outLog[0].majId !== 64'h0) begin failures++; $display("FAIL rmw_majId got=%0d exp=0", outLog[0].majId); end
            end
        end
        enable_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap(1'b0, 64'h0);
        test_wrap(1'b1, 64'h1_0000_0000);
        test_push_pop();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end instruction fetch block that produces the instruction stream consumed by the decode unit. Maintains the PC and requests 32-bit instruction words from the instruction memory/cache over a req/ack handshake. Buffers returned words in a small queue and presents one instruction per cycle to decode, tagged with address, mode, PID, TID and a monotonically increasing major ID. Honours decode back-pressure via stall_i and supports branch redirect with in-flight discard.

Parameters:
addressWidth, 64, PC and memory address width
instructionWidth, 32, instruction word width
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID counter width
queueDepth, 4, instruction queue entries (power of 2, >=2)
resetVector, 0, PC value after reset

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
enable_i  in  1  fetch enable; 0 = issue no new requests and no pops
stall_i  in  1  decode back-pressure; 1 = do not present a new instruction
redirect_i  in  1  branch/exception redirect pulse
redirectAddress_i  in  addressWidth  new PC on redirect
is64Bit_i  in  1  current machine mode (1 = 64-bit)
pid_i  in  PidSize  current process ID
tid_i  in  TidSize  current thread ID
memReq_o  out  1  memory read request
memAddress_o  out  addressWidth  word address of request
memAck_i  in  1  memory response valid
memData_i  in  instructionWidth  returned instruction word
enable_o  out  1  instruction valid to decode
instruction_o  out  instructionWidth  instruction word
instructionAddress_o  out  addressWidth  instruction address
is64Bit_o  out  1  mode tag
instructionPid_o  out  PidSize  PID tag
instructionTid_o  out  TidSize  TID tag
instructionMajId_o  out  instructionCounterWidth  major ID

Behaviour:
- Reset (reset_i=0, async): PC=resetVector, queue empty, FSM=IDLE, majId counter=0; all outputs 0.
- Queue entry = {instruction, address, is64Bit, pid, tid}; tags captured at push time.
- FSM IDLE: if enable_i & !redirect_i & (count + 0 < queueDepth) -> assert memReq_o, memAddress_o=PC, go WAIT.
- WAIT: memReq_o and memAddress_o held stable until memAck_i. On memAck_i: push entry, PC += 4, return to IDLE (next request may issue the following cycle).
- WAIT + redirect_i (no ack same cycle): go DRAIN. memReq_o stays asserted until memAck_i; the returned data is dropped and PC is not advanced; then IDLE.
- Redirect with ack in the same cycle: data dropped.
- Redirect (any state): PC = redirectAddress_i with bits [62:63] forced to 0; queue flushed; enable_o=0 next cycle.
- Request is issued only when a slot is free (count < queueDepth), so a push never overflows.
- Pop when queue non-empty & enable_i & !stall_i & !redirect_i. Output registers load the head next edge; enable_o=1 for exactly that cycle; majId counter increments per pop.
- No pop: enable_o=0, other outputs hold their last value.
- Push and pop in the same cycle are allowed; count unchanged. Empty-queue pop is impossible; no bypass, so minimum latency from memAck_i to enable_o is 2 cycles.
- PC increment: when is64Bit_i=0, PC[0:31] is forced 0 and the low word wraps 0xFFFFFFFC -> 0. 64-bit mode wraps at 2^64.
- Major ID is not reset by redirect; it wraps at 2^instructionCounterWidth.
- Reset asserted mid-WAIT: memReq_o drops immediately. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package: FSM state encoding (IDLE, WAIT, DRAIN), default widths, queue-entry field offsets.
- Sub-module fetch_queue: synchronous FIFO, depth queueDepth, push/pop/flush, full/empty/count.

Test Plan:
1. Reset release, enable_i=1, memory acks 1 cycle after req -> memAddress_o = 0x0, 0x4, 0x8 …; enable_o pulses carry these addresses with majId 0, 1, 2.
2. stall_i=1 for 10 cycles -> exactly 4 words fetched then memReq_o stays 0; on stall release, 4 consecutive enable_o with addresses 0x0..0xC and no loss or duplication.
3. redirect_i to 0x1002 while in WAIT, ack 3 cycles later -> stale word never appears; next request is address 0x1000; queue contents flushed.
4. is64Bit_i=0, PC=0xFFFFFFFC -> next request address 0x0; with is64Bit_i=1 the next address is 0x100000000.
5. Simultaneous memAck_i and pop with queue at depth 3 -> count stays 3; order preserved.
6. reset_i=0 asserted mid-WAIT -> memReq_o=0 and enable_o=0 the same cycle (async); after release, fetch restarts at resetVector with majId 0.
